mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Upstream feeder for the pipelined MIPS32 core: accepts a program as a stream of 32-bit instruction words and writes them into the core's instruction/data memory from address 0. It holds the core idle during loading, optionally appends a HLT guard word, then releases the core with a one-cycle start pulse. It then watches for the core's halt to report completion. This replaces hierarchical memory pokes in benches and gives the core a synthesizable boot path.

## Interface
- ADDR_W, 10, memory word-address width (1024-word memory)
- HLT_WORD, 32'hfc000000, guard word appended after the last program word
- APPEND_HLT, 1, 1 = write HLT_WORD after the last word; 0 = no guard
- clk1  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR
- in_valid  in  1  upstream word valid
- in_data  in  32  instruction word
- in_last  in  1  marks final program word; qualified by in_valid
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- cpu_hold  out  1  core must stay halted while 1
- cpu_start  out  1  one-cycle pulse: core clears HALTED and TAKEN_BRANCH, sets PC = 0
- cpu_halted  in  1  core's HALTED flag
- done  out  1  program ran to HLT
- err  out  1  overflow: program plus guard exceeded memory
- word_count  out  ADDR_W+1  program words accepted, guard excluded

## Operation
- States: IDLE, LOAD, GUARD, LAUNCH, RUN, DONE, ERR.
- IDLE/DONE/ERR + start: go to LOAD. Clear write pointer, word_count, done, and err. Force cpu_hold = 1.
- LOAD: in_ready = 1. A handshake (in_valid & in_ready) writes in_data at the pointer, then increments the pointer and word_count.
- Handshake with in_last:
  - APPEND_HLT = 1: go to GUARD.
  - APPEND_HLT = 0: go to LAUNCH.
- Handshake at pointer 2^ADDR_W-1 without in_last: the word is written, then go to ERR.
- Handshake with in_last at pointer 2^ADDR_W-1 and APPEND_HLT = 1: the word is written, the guard is not, and the state goes to ERR.
- GUARD: one cycle; writes HLT_WORD at the pointer; in_ready = 0; go to LAUNCH.
- LAUNCH: one cycle; cpu_start = 1, cpu_hold = 0; go to RUN.
- RUN: cpu_hold = 0. Go to DONE when cpu_halted = 1, sampled from the cycle after LAUNCH onward. The LAUNCH-cycle value is stale and is ignored.
- DONE: done = 1, cpu_hold = 1. ERR: err = 1, cpu_hold = 1, core never started.
- start is ignored in LOAD, GUARD, LAUNCH, RUN.
- Pointer does not wrap; overflow always goes to ERR.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, cpu_start 0, done 0, err 0, word_count 0; state IDLE.
- rst_n low in any state, including mid-load or mid-run, returns all of the above next edge. Partially written memory is left as is.
- mem_we/mem_addr/mem_wdata are registered: a handshake at edge t drives the write during cycle t+1. mem_we is 1 for exactly one cycle per word. The guard write follows the last program write back-to-back.
- Throughput is one word per cycle. in_ready is combinational from state only, with no dependence on in_valid.
- Latency from the last handshake edge to the cpu_start pulse: 2 cycles with guard, 1 cycle without.
- word_count updates on the handshake edge.

## Structure
- Shared package mips32_pkg: HLT opcode constant (6'b111111) and full HLT_WORD, loader state enum, MEM_DEPTH derived from ADDR_W.
- Single module; no sub-module needed. An optional mips32_boot_top wraps the loader with pipe_MIPS32 and is outside this block.

## Test plan
- Nine-word stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last on the ninth word), APPEND_HLT = 1:
  - mem[0..8] hold those words and mem[9] = fc000000; word_count = 9.
  - One cpu_start pulse two cycles after the last handshake.
  - Core runs to R1 = 10, R2 = 20, R3 = 25, R4 = 30, R5 = 55; done = 1.
- Backpressure: in_valid toggled every other cycle, same program -> identical memory image, no duplicate or dropped writes, mem_we count = 10.
- Overflow with ADDR_W = 3: 9 words, no in_last -> 8 writes, err = 1, cpu_start never pulses, cpu_hold stays 1. Then start with a 2-word stream -> err clears and the load completes.
- Last word at address 7 with ADDR_W = 3, APPEND_HLT = 1 -> err = 1, no guard write.
- rst_n asserted on the 4th LOAD handshake -> next cycle all outputs are at reset values; a following start reloads from address 0.
- APPEND_HLT = 0, single word fc000000 with in_last -> cpu_start one cycle after the handshake; done asserts once cpu_halted rises.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared constants and types for the MIPS32 boot path: HLT encoding,
// loader state enumeration and memory sizing helpers.
package mips32_pkg;

    // Major opcode of the HLT instruction and the complete instruction word.
    localparam logic [5:0]  HLT_OPCODE = 6'b111111;
    localparam logic [31:0] HLT_INSTR  = {HLT_OPCODE, 26'd0};

    // Default memory geometry of the core (word addressed).
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned MEM_DEPTH  = 32'd1 << DEF_ADDR_W;

    // Number of words addressable with an addr_w-bit word address.
    function automatic int unsigned mem_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_GUARD  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

endpackage

// File: rtl/mips32_prog_loader.sv
// Boot loader for the pipelined MIPS32 core. Streams program words into the
// core memory from address 0, optionally appends a HLT guard word, releases
// the core with a one-cycle start pulse and reports when the core halts.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter logic [31:0] HLT_WORD   = HLT_INSTR,
    parameter bit          APPEND_HLT = 1'b1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    input  logic              cpu_halted,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    loader_state_e     r_state;
    loader_state_e     w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_cpu_start;
    logic              r_done;
    logic              r_err;
    logic              w_hs;
    logic              w_at_end;
    logic              w_begin;

    // Ready depends on state only so upstream never sees a valid->ready loop.
    assign in_ready = (r_state == ST_LOAD);
    assign w_hs     = in_valid & in_ready;
    assign w_at_end = (r_ptr == LAST_ADDR);
    assign w_begin  = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign cpu_start  = r_cpu_start;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

    // Next-state decode; overflow is detected on the word written at the top address.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: begin
                if (w_hs && in_last) begin
                    if (APPEND_HLT && w_at_end) begin
                        w_state_nxt = ST_ERR;
                    end else if (APPEND_HLT) begin
                        w_state_nxt = ST_GUARD;
                    end else begin
                        w_state_nxt = ST_LAUNCH;
                    end
                end else if (w_hs && w_at_end) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_GUARD:  w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // The halted flag seen while the start pulse is out is from the previous run.
                if (cpu_halted && !r_cpu_start) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered write port, pointer/count and core control outputs.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_cpu_start  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= w_hs || (r_state == ST_GUARD);
            if (w_begin) begin
                r_ptr        <= '0;
                r_word_count <= '0;
            end else if (w_hs) begin
                r_mem_addr   <= r_ptr;
                r_mem_wdata  <= in_data;
                r_ptr        <= r_ptr + PTR_ONE;
                r_word_count <= r_word_count + CNT_ONE;
            end else if (r_state == ST_GUARD) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= HLT_WORD;
            end else begin
                r_ptr <= r_ptr;
            end
            r_cpu_start <= (r_state == ST_LAUNCH);
            r_cpu_hold  <= (w_state_nxt != ST_RUN);
            r_done      <= (w_state_nxt == ST_DONE);
            r_err       <= (w_state_nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: three instances (default geometry with guard,
// 8-word memory with guard, 16-word memory without guard) driven by random
// streams, checked every cycle against a transaction-level model, plus
// literal expectations for the reference program and the boundary cases.
module tb_mips32_prog_loader;

    localparam logic [31:0] HLT = 32'hfc000000;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n;
    logic        start_a[3], valid_a[3], last_a[3], halted_a[3];
    logic [31:0] data_a[3];

    logic        o_ready[3], o_we[3], o_hold[3], o_start[3], o_done[3], o_err[3];
    logic [9:0]  o_addr[3];
    logic [31:0] o_wdata[3];
    logic [10:0] o_cnt[3];

    logic        x0_rdy, x0_we, x0_hold, x0_st, x0_done, x0_err;
    logic [9:0]  x0_addr;  logic [31:0] x0_wd;  logic [10:0] x0_cnt;
    logic        x1_rdy, x1_we, x1_hold, x1_st, x1_done, x1_err;
    logic [2:0]  x1_addr;  logic [31:0] x1_wd;  logic [3:0]  x1_cnt;
    logic        x2_rdy, x2_we, x2_hold, x2_st, x2_done, x2_err;
    logic [3:0]  x2_addr;  logic [31:0] x2_wd;  logic [4:0]  x2_cnt;

    mips32_prog_loader #(.ADDR_W(10), .APPEND_HLT(1'b1)) u_dut0 (
        .clk1(clk1), .rst_n(rst_n), .start(start_a[0]), .in_valid(valid_a[0]),
        .in_data(data_a[0]), .in_last(last_a[0]), .in_ready(x0_rdy), .mem_we(x0_we),
        .mem_addr(x0_addr), .mem_wdata(x0_wd), .cpu_hold(x0_hold), .cpu_start(x0_st),
        .cpu_halted(halted_a[0]), .done(x0_done), .err(x0_err), .word_count(x0_cnt));
    mips32_prog_loader #(.ADDR_W(3), .APPEND_HLT(1'b1)) u_dut1 (
        .clk1(clk1), .rst_n(rst_n), .start(start_a[1]), .in_valid(valid_a[1]),
        .in_data(data_a[1]), .in_last(last_a[1]), .in_ready(x1_rdy), .mem_we(x1_we),
        .mem_addr(x1_addr), .mem_wdata(x1_wd), .cpu_hold(x1_hold), .cpu_start(x1_st),
        .cpu_halted(halted_a[1]), .done(x1_done), .err(x1_err), .word_count(x1_cnt));
    mips32_prog_loader #(.ADDR_W(4), .APPEND_HLT(1'b0)) u_dut2 (
        .clk1(clk1), .rst_n(rst_n), .start(start_a[2]), .in_valid(valid_a[2]),
        .in_data(data_a[2]), .in_last(last_a[2]), .in_ready(x2_rdy), .mem_we(x2_we),
        .mem_addr(x2_addr), .mem_wdata(x2_wd), .cpu_hold(x2_hold), .cpu_start(x2_st),
        .cpu_halted(halted_a[2]), .done(x2_done), .err(x2_err), .word_count(x2_cnt));

    // Gather the three instances into uniform arrays.
    always_comb begin
        o_ready = '{x0_rdy, x1_rdy, x2_rdy};
        o_we    = '{x0_we, x1_we, x2_we};
        o_hold  = '{x0_hold, x1_hold, x2_hold};
        o_start = '{x0_st, x1_st, x2_st};
        o_done  = '{x0_done, x1_done, x2_done};
        o_err   = '{x0_err, x1_err, x2_err};
        o_addr  = '{x0_addr, {7'd0, x1_addr}, {6'd0, x2_addr}};
        o_wdata = '{x0_wd, x1_wd, x2_wd};
        o_cnt   = '{x0_cnt, {7'd0, x1_cnt}, {6'd0, x2_cnt}};
    end

    int  depth[3] = '{1024, 8, 16};
    bit  app[3]   = '{1'b1, 1'b1, 1'b0};

    int n_tot = 0, n_pass = 0, cyc = 0;

    // Behavioural model: phase of the load/run sequence plus expected outputs.
    int          m_ph[3], m_ptr[3], m_cnt[3];
    bit          m_fresh[3];
    bit          model_on = 1'b0;
    logic        e_ready[3], e_we[3], e_hold[3], e_start[3], e_done[3], e_err[3];
    logic [9:0]  e_addr[3];
    logic [31:0] e_wdata[3];

    // Environment state: captured memory, counters, fake core.
    logic [31:0] cap[3][1024];
    int          we_cnt[3] = '{0, 0, 0}, n_start[3] = '{0, 0, 0};
    int          st_cyc[3], last_hs[3], cd[3] = '{0, 0, 0};
    bit          sprev[3] = '{0, 0, 0};
    logic [31:0] prog[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
    endtask

    task automatic model_step(input int k);
        if (!rst_n) begin
            m_ph[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_fresh[k] = 0;
            e_we[k] = 0; e_addr[k] = '0; e_wdata[k] = '0; e_start[k] = 0;
            model_on = 1'b1;
        end else begin
            e_we[k] = 0; e_start[k] = 0;
            case (m_ph[k])
                0, 5, 6: if (start_a[k]) begin m_ph[k] = 1; m_ptr[k] = 0; m_cnt[k] = 0; end
                1: if (valid_a[k]) begin
                    e_we[k] = 1; e_addr[k] = 10'(m_ptr[k]); e_wdata[k] = data_a[k];
                    m_cnt[k]++;
                    if (m_ptr[k] == depth[k] - 1 && (!last_a[k] || app[k])) m_ph[k] = 6;
                    else if (last_a[k]) m_ph[k] = app[k] ? 2 : 3;
                    m_ptr[k]++;
                end
                2: begin e_we[k] = 1; e_addr[k] = 10'(m_ptr[k]); e_wdata[k] = HLT; m_ph[k] = 3; end
                3: begin m_ph[k] = 4; e_start[k] = 1; m_fresh[k] = 1; end
                4: begin if (!m_fresh[k] && halted_a[k]) m_ph[k] = 5; m_fresh[k] = 0; end
                default: m_ph[k] = 0;
            endcase
        end
        e_ready[k] = (m_ph[k] == 1);
        e_hold[k]  = (m_ph[k] != 4);
        e_done[k]  = (m_ph[k] == 5);
        e_err[k]   = (m_ph[k] == 6);
    endtask

    // Advance the model on every active edge using the inputs the DUT sees.
    always @(posedge clk1) begin
        cyc++;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    // Per-cycle comparison and capture of the write port, away from the edge.
    always @(negedge clk1) begin
        for (int k = 0; k < 3; k++) begin
            if (model_on)
                chk($sformatf("outputs[%0d]", k),
                    {5'd0, o_ready[k], o_we[k], o_addr[k], o_wdata[k], o_hold[k], o_start[k],
                     o_done[k], o_err[k], o_cnt[k]},
                    {5'd0, e_ready[k], e_we[k], e_addr[k], e_wdata[k], e_hold[k], e_start[k],
                     e_done[k], e_err[k], 11'(m_cnt[k])});
            if (o_we[k] === 1'b1) begin cap[k][o_addr[k]] = o_wdata[k]; we_cnt[k]++; end
            if (o_start[k] === 1'b1) begin st_cyc[k] = cyc; n_start[k]++; end
            sprev[k] = (o_start[k] === 1'b1);
        end
    end

    // Fake core: HALTED clears after the start pulse and sets again a few cycles later.
    always begin
        @(posedge clk1); #1;
        for (int k = 0; k < 3; k++) begin
            if (sprev[k]) begin halted_a[k] = 1'b0; cd[k] = $urandom_range(2, 6); end
            else if (!halted_a[k]) begin cd[k]--; if (cd[k] <= 0) halted_a[k] = 1'b1; end
        end
    end

    task automatic tick();
        @(posedge clk1); #1;
    endtask

    task automatic do_start(input int k);
        start_a[k] = 1'b1; tick(); start_a[k] = 1'b0;
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle per word, 2 = random idles.
    task automatic send(input int k, input int n, input bit with_last, input int gap,
                        input bit noise, output int acc);
        bit stop = 1'b0;
        acc = 0;
        for (int i = 0; i < n && !stop; i++) begin
            bit sent = 1'b0;
            for (int t = 0; t < 8 && !sent; t++) begin
                bit v;
                if (o_ready[k] !== 1'b1) begin stop = 1'b1; break; end
                v = (gap == 0) ? 1'b1 : (gap == 1) ? (t == 1) : (t >= 3 || $urandom_range(0, 1) == 1);
                valid_a[k] = v;
                data_a[k]  = v ? prog[i] : $urandom;
                last_a[k]  = with_last && (i == n - 1);
                start_a[k] = noise && ($urandom_range(0, 3) == 0);
                tick();
                if (v) begin sent = 1'b1; acc++; last_hs[k] = cyc; end
            end
        end
        valid_a[k] = 1'b0; last_a[k] = 1'b0; start_a[k] = 1'b0;
    endtask

    task automatic wait_end(input int k);
        for (int t = 0; t < 200; t++) begin
            if (o_done[k] === 1'b1 || o_err[k] === 1'b1) break;
            tick();
        end
        chk($sformatf("end_reached[%0d]", k), 64'(o_done[k] | o_err[k]), 64'd1);
    endtask

    logic [31:0] ref_prog[9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                                 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    initial begin
        int acc, w0, ns;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 0; valid_a[k] = 0; last_a[k] = 0; data_a[k] = '0; halted_a[k] = 1'b1;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_hold", 64'(o_hold[0]), 64'd1);
        chk("reset_ready", 64'(o_ready[0]), 64'd0);
        chk("reset_count", 64'(o_cnt[0]), 64'd0);

        // Reference program, back-to-back, with guard.
        for (int i = 0; i < 9; i++) prog[i] = ref_prog[i];
        do_start(0);
        send(0, 9, 1'b1, 0, 1'b0, acc);
        chk("ref_accepted", 64'(acc), 64'd9);
        wait_end(0);
        chk("ref_count", 64'(o_cnt[0]), 64'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("ref_mem%0d", i), 64'(cap[0][i]), 64'(ref_prog[i]));
        chk("ref_guard", 64'(cap[0][9]), 64'hfc000000);
        chk("ref_start_latency", 64'(st_cyc[0] - last_hs[0]), 64'd2);
        chk("ref_done", 64'(o_done[0]), 64'd1);

        // Same program with valid every other cycle.
        for (int i = 0; i < 10; i++) cap[0][i] = '0;
        w0 = we_cnt[0];
        do_start(0);
        send(0, 9, 1'b1, 1, 1'b0, acc);
        wait_end(0);
        chk("bp_we_count", 64'(we_cnt[0] - w0), 64'd10);
        for (int i = 0; i < 9; i++) chk($sformatf("bp_mem%0d", i), 64'(cap[0][i]), 64'(ref_prog[i]));
        chk("bp_guard", 64'(cap[0][9]), 64'hfc000000);

        // Overflow of the 8-word memory without last, then recovery.
        for (int i = 0; i < 9; i++) prog[i] = $urandom;
        w0 = we_cnt[1]; ns = n_start[1];
        do_start(1);
        send(1, 9, 1'b0, 0, 1'b0, acc);
        repeat (4) tick();
        chk("ovf_accepted", 64'(acc), 64'd8);
        chk("ovf_err", 64'(o_err[1]), 64'd1);
        chk("ovf_we_count", 64'(we_cnt[1] - w0), 64'd8);
        chk("ovf_no_start", 64'(n_start[1] - ns), 64'd0);
        chk("ovf_hold", 64'(o_hold[1]), 64'd1);
        do_start(1);
        chk("ovf_err_cleared", 64'(o_err[1]), 64'd0);
        send(1, 2, 1'b1, 0, 1'b0, acc);
        wait_end(1);
        chk("rec_done", 64'(o_done[1]), 64'd1);
        chk("rec_mem1", 64'(cap[1][1]), 64'(prog[1]));
        chk("rec_guard", 64'(cap[1][2]), 64'hfc000000);

        // Last word lands on the top address: no room for the guard.
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        w0 = we_cnt[1];
        do_start(1);
        send(1, 8, 1'b1, 0, 1'b0, acc);
        repeat (3) tick();
        chk("top_err", 64'(o_err[1]), 64'd1);
        chk("top_we_count", 64'(we_cnt[1] - w0), 64'd8);
        chk("top_count", 64'(o_cnt[1]), 64'd8);

        // Reset on the fourth handshake, then reload from address 0.
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            valid_a[0] = 1'b1; data_a[0] = $urandom;
            if (i == 3) rst_n = 1'b0;
            tick();
        end
        rst_n = 1'b1; valid_a[0] = 1'b0;
        chk("rst_count", 64'(o_cnt[0]), 64'd0);
        chk("rst_we", 64'(o_we[0]), 64'd0);
        chk("rst_hold", 64'(o_hold[0]), 64'd1);
        chk("rst_ready", 64'(o_ready[0]), 64'd0);
        for (int i = 0; i < 5; i++) prog[i] = $urandom;
        do_start(0);
        send(0, 5, 1'b1, 2, 1'b0, acc);
        wait_end(0);
        chk("reload_mem0", 64'(cap[0][0]), 64'(prog[0]));
        chk("reload_guard", 64'(cap[0][5]), 64'hfc000000);
        chk("reload_count", 64'(o_cnt[0]), 64'd5);

        // No guard: single HLT word.
        prog[0] = HLT;
        w0 = we_cnt[2];
        do_start(2);
        send(2, 1, 1'b1, 0, 1'b0, acc);
        wait_end(2);
        chk("ng_start_latency", 64'(st_cyc[2] - last_hs[2]), 64'd1);
        chk("ng_done", 64'(o_done[2]), 64'd1);
        chk("ng_we_count", 64'(we_cnt[2] - w0), 64'd1);
        chk("ng_mem0", 64'(cap[2][0]), 64'hfc000000);

        // Random programs with random gaps and ignored start noise.
        for (int it = 0; it < 8; it++) begin
            int k, n;
            k = (it % 2 == 1) ? 2 : 0;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            w0 = we_cnt[k];
            do_start(k);
            send(k, n, 1'b1, $urandom_range(0, 2), 1'b1, acc);
            wait_end(k);
            chk("rnd_done", 64'(o_done[k]), 64'd1);
            chk("rnd_count", 64'(o_cnt[k]), 64'(n));
            chk("rnd_we_count", 64'(we_cnt[k] - w0), 64'(n + int'(app[k])));
            chk("rnd_last_word", 64'(cap[k][n - 1]), 64'(prog[n - 1]));
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
